// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - AHB-Lite encodings and byte-lane select helper
// Purpose: bus encodings shared by AHB-Lite slaves, plus the lane-mask
//   function that turns HSIZE and the low address bits into byte selects.
// Ports: none (package).
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte mask 2**hsize lanes wide starting at lane addr_lo, clipped to sw lanes.
  // Supports up to four lanes (32-bit data path).
  function automatic logic [3:0] ahb_lane_sel(input logic [2:0] hsize,
                                              input logic [1:0] addr_lo,
                                              input int         sw);
    logic [3:0] m;
    logic [3:0] lanes;
    case (hsize)
      HSIZE_BYTE:  m = 4'b0001;
      HSIZE_HWORD: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    m     = m << addr_lo;
    lanes = 4'((1 << sw) - 1);
    return m & lanes;
  endfunction

endpackage

// File: rtl/ahb3_spram_ctrl_if.sv
// rtl/ahb3_spram_ctrl_if.sv - AHB-Lite slave port bundle
// Purpose: groups the AHB-Lite address/data phase signals of one slave port.
// Ports (signals):
//   HSEL, HADDR[PLEN], HWRITE, HSIZE[3], HTRANS[2], HWDATA[XLEN], HREADY : master -> slave
//   HREADYOUT, HRESP, HRDATA[XLEN]                                       : slave -> master
interface ahb3_spram_ctrl_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
) ();

  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [1:0]      HTRANS;
  logic [XLEN-1:0] HWDATA;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;
  logic [XLEN-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb3_spram_ctrl.sv
// rtl/ahb3_spram_ctrl.sv - AHB-Lite slave front-end for a single-port SRAM
// Purpose: turns AHB-Lite address/data phases into SRAM strobes. Reads and
//   writes are zero wait; a read arriving during a write data phase takes one
//   wait state because the single SRAM port is busy with the write.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ahb (slave)         AHB-Lite slave port (HSEL..HRDATA)
//   ce, we, oe          SRAM chip/write/output enable
//   waddr[WORD_AW]      SRAM word address
//   din[XLEN]           SRAM write data (HWDATA)
//   sel[SW]             SRAM byte selects
//   dout[XLEN]          SRAM read data, valid the cycle after the read address
module ahb3_spram_ctrl
  import ahb3lite_pkg::*;
#(
  parameter int              PLEN          = 32,
  parameter int              XLEN          = 32,
  parameter int              WORD_AW       = PLEN - $clog2(XLEN / 8),
  parameter logic [PLEN-1:0] BASE_ADDR     = '0,
  parameter logic [PLEN-1:0] MEM_SIZE_BYTE = 'h1000
) (
  input  logic                 clk,
  input  logic                 rst,
  ahb3_spram_ctrl_if.slave     ahb,
  output logic                 ce,
  output logic                 we,
  output logic                 oe,
  output logic [WORD_AW-1:0]   waddr,
  output logic [XLEN-1:0]      din,
  output logic [XLEN/8-1:0]    sel,
  input  logic [XLEN-1:0]      dout
);

  localparam int         SW        = XLEN / 8;
  localparam int         LW        = $clog2(SW);
  localparam logic [2:0] MAX_HSIZE = 3'(LW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_AW-1:0] waddr_q, waddr_d;
  logic [SW-1:0]      sel_q, sel_d;

  // Address-phase decode
  logic [PLEN-1:0]    off;
  logic [WORD_AW-1:0] off_word;
  logic               accept;
  logic               size_err;
  logic               misalign;
  logic               range_err;
  logic               dec_err;
  logic [3:0]         lane_mask;
  logic [SW-1:0]      lane_sel;

  assign off       = ahb.HADDR - BASE_ADDR;
  assign off_word  = WORD_AW'(off >> LW);
  assign accept    = ahb.HSEL & ahb.HREADY &
                     ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));
  assign size_err  = ahb.HSIZE > MAX_HSIZE;
  assign misalign  = ((ahb.HSIZE == HSIZE_HWORD) & ahb.HADDR[0]) |
                     ((ahb.HSIZE == HSIZE_WORD) & (|ahb.HADDR[1:0]));
  // Addresses below BASE_ADDR wrap to a huge offset and fail this test too.
  assign range_err = off >= MEM_SIZE_BYTE;
  assign dec_err   = range_err | size_err | misalign;
  assign lane_mask = ahb_lane_sel(ahb.HSIZE, ahb.HADDR[1:0] & 2'(SW - 1), SW);
  assign lane_sel  = lane_mask[SW-1:0];

  // Combinational strobes before reset gating
  logic               ce_c, we_c, oe_c;
  logic [WORD_AW-1:0] waddr_c;
  logic [SW-1:0]      sel_c;
  logic               hreadyout_c;
  logic               hresp_c;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    sel_d       = sel_q;
    ce_c        = 1'b0;
    we_c        = 1'b0;
    oe_c        = 1'b0;
    waddr_c     = waddr_q;
    sel_c       = sel_q;
    hreadyout_c = 1'b1;
    hresp_c     = HRESP_OKAY;

    case (state_q)
      S_WR: begin
        ce_c = 1'b1;
        we_c = 1'b1;
      end
      S_RDW: begin
        hreadyout_c = 1'b0;
        ce_c        = 1'b1;
        oe_c        = 1'b1;
        state_d     = S_RD;
      end
      S_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = HRESP_ERROR;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        hresp_c = HRESP_ERROR;
      end
      default: ;
    endcase

    // States whose data phase completes with HREADYOUT=1 may take a new address.
    if ((state_q != S_RDW) && (state_q != S_ERR1) && ahb.HREADY) begin
      if (accept) begin
        if (dec_err) begin
          state_d = S_ERR1;
        end else if (ahb.HWRITE) begin
          state_d = S_WR;
          waddr_d = off_word;
          sel_d   = lane_sel;
        end else if (state_q == S_WR) begin
          // Port busy with the write: park the read address for one cycle.
          state_d = S_RDW;
          waddr_d = off_word;
          sel_d   = lane_sel;
        end else begin
          state_d = S_RD;
          ce_c    = 1'b1;
          oe_c    = 1'b1;
          waddr_c = off_word;
          sel_c   = lane_sel;
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      sel_q   <= sel_d;
    end
  end

  // Strobes are gated during reset so a write data phase cut by reset never commits.
  assign ce    = ce_c & ~rst;
  assign we    = we_c & ~rst;
  assign oe    = oe_c & ~rst;
  assign waddr = waddr_c;
  assign sel   = sel_c;
  assign din   = ahb.HWDATA;

  assign ahb.HREADYOUT = hreadyout_c;
  assign ahb.HRESP     = hresp_c;
  assign ahb.HRDATA    = dout;

endmodule

// File: tb/tb_ahb3_spram_ctrl.sv
// tb/tb_ahb3_spram_ctrl.sv - directed bench for the AHB-Lite SRAM front-end
module tb_ahb3_spram_ctrl;
  import ahb3lite_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  logic hready_low;
  always #5 clk = ~clk;

  ahb3_spram_ctrl_if #(.PLEN(32), .XLEN(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT & ~hready_low;

  logic        ce, we, oe;
  logic [29:0] waddr;
  logic [31:0] din;
  logic [3:0]  sel;
  logic [31:0] dout;

  ahb3_spram_ctrl #(
    .PLEN(32), .XLEN(32), .WORD_AW(30), .BASE_ADDR(32'h0), .MEM_SIZE_BYTE(32'h1000)
  ) dut (
    .clk(clk), .rst(rst), .ahb(bus),
    .ce(ce), .we(we), .oe(oe), .waddr(waddr), .din(din), .sel(sel), .dout(dout)
  );

  // SRAM model: registered read, byte-lane writes.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[0] <= 32'h11111111;
      mem[1] <= 32'h22222222;
      dout   <= '0;
    end else begin
      if (ce && we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[waddr[9:0]][8*b +: 8] <= din[8*b +: 8];
      if (ce && oe) dout <= mem[waddr[9:0]];
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                       input logic [2:0] hsize, input logic [31:0] haddr,
                       input logic [31:0] hwdata);
    bus.HSEL   = hsel;
    bus.HTRANS = htrans;
    bus.HWRITE = hwrite;
    bus.HSIZE  = hsize;
    bus.HADDR  = haddr;
    bus.HWDATA = hwdata;
  endtask

  // ctl = {HREADYOUT, HRESP, ce, we, oe}
  localparam logic [4:0] C_IDLE = 5'b10000;
  localparam logic [4:0] C_WR   = 5'b10110;
  localparam logic [4:0] C_RD   = 5'b10101;
  localparam logic [4:0] C_RDW  = 5'b00101;
  localparam logic [4:0] C_E1   = 5'b01000;
  localparam logic [4:0] C_E2   = 5'b11000;
  localparam logic [4:0] C_E2RD = 5'b11101;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [4:0]  ctl;
    logic [29:0] wa;
    logic [3:0]  sl;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                              input logic [2:0] hsize, input logic [31:0] haddr,
                              input logic [31:0] hwdata, input logic [4:0] ctl,
                              input logic [29:0] wa, input logic [3:0] sl,
                              input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.hsel = hsel; v.htrans = htrans; v.hwrite = hwrite; v.hsize = hsize;
    v.haddr = haddr; v.hwdata = hwdata; v.ctl = ctl; v.wa = wa; v.sl = sl;
    v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  localparam int NV = 30;
  vec_t vecs [NV];

  logic [4:0] ctl_now;
  assign ctl_now = {bus.HREADYOUT, bus.HRESP, ce, we, oe};

  initial begin
    vecs[0]  = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[1]  = mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,  32'h13,   32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[2]  = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'hAB000000, C_WR,   4, 4'h8, 0, 0);
    vecs[3]  = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        C_RD,   4, 4'hF, 0, 0);
    vecs[4]  = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'hAB000000);
    vecs[5]  = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h10,   32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[6]  = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'hDEADBEEF, C_WR,   4, 4'hF, 0, 0);
    vecs[7]  = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_RDW,  4, 4'hF, 0, 0);
    vecs[8]  = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'hDEADBEEF);
    vecs[9]  = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h0,    32'h0,        C_RD,   0, 4'hF, 0, 0);
    vecs[10] = mk(1, HTRANS_SEQ,    0, HSIZE_WORD,  32'h4,    32'h0,        C_RD,   1, 4'hF, 1, 32'h11111111);
    vecs[11] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'h22222222);
    vecs[12] = mk(1, HTRANS_NONSEQ, 0, HSIZE_HWORD, 32'h11,   32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[13] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_E1,   0, 4'h0, 0, 0);
    vecs[14] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_E2,   0, 4'h0, 0, 0);
    vecs[15] = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h1000, 32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[16] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h12345678, C_E1,   0, 4'h0, 0, 0);
    vecs[17] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_E2,   0, 4'h0, 0, 0);
    vecs[18] = mk(1, HTRANS_NONSEQ, 0, 3'd3,        32'h8,    32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[19] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h4,    32'h0,        C_E1,   0, 4'h0, 0, 0);
    vecs[20] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h4,    32'h0,        C_E2RD, 1, 4'hF, 0, 0);
    vecs[21] = mk(1, HTRANS_BUSY,   0, HSIZE_WORD,  32'h8,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'h22222222);
    vecs[22] = mk(1, HTRANS_BUSY,   0, HSIZE_WORD,  32'h8,    32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[23] = mk(1, HTRANS_NONSEQ, 1, HSIZE_HWORD, 32'h2,    32'h0,        C_IDLE, 0, 4'h0, 0, 0);
    vecs[24] = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h8,    32'h5A5A0000, C_WR,   0, 4'hC, 0, 0);
    vecs[25] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h0,    32'hCAFEF00D, C_WR,   2, 4'hF, 0, 0);
    vecs[26] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_RDW,  0, 4'hF, 0, 0);
    vecs[27] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'h5A5A1111);
    vecs[28] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h8,    32'h0,        C_RD,   2, 4'hF, 0, 0);
    vecs[29] = mk(0, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        C_IDLE, 0, 4'h0, 1, 32'hCAFEF00D);

    rst        = 1'b1;
    preload    = 1'b1;
    hready_low = 1'b0;
    drive(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check("reset ctl", 32'(ctl_now), 32'(C_IDLE));
    check("reset hrdata", bus.HRDATA, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].hsel, vecs[i].htrans, vecs[i].hwrite, vecs[i].hsize,
            vecs[i].haddr, vecs[i].hwdata);
      @(negedge clk);
      check($sformatf("row%0d ctl", i), 32'(ctl_now), 32'(vecs[i].ctl));
      if (vecs[i].ctl[2]) begin
        check($sformatf("row%0d waddr", i), 32'(waddr), 32'(vecs[i].wa));
        check($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].sl));
      end
      if (vecs[i].ctl[1])
        check($sformatf("row%0d din", i), din, vecs[i].hwdata);
      if (vecs[i].chk_rd)
        check($sformatf("row%0d hrdata", i), bus.HRDATA, vecs[i].rd);
      @(posedge clk);
      #1;
    end

    // HREADY low: a presented write must not be accepted.
    hready_low = 1'b1;
    drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h0);
    @(negedge clk);
    check("nohready ce", 32'(ce), 32'h0);
    @(posedge clk);
    #1 hready_low = 1'b0;
    drive(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    check("nohready we", 32'(we), 32'h0);
    @(posedge clk);
    #1;

    // Reset during a write data phase: no write, back to idle.
    drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    check("rst we", 32'(we), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst after ctl", 32'(ctl_now), 32'(C_IDLE));
    @(posedge clk);
    #1 drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0);
    @(negedge clk);
    check("rst read ctl", 32'(ctl_now), 32'(C_RD));
    @(posedge clk);
    #1 drive(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    @(negedge clk);
    check("rst mem unchanged", bus.HRDATA, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
